// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debounce filter,
// press/release edge pulses and per-channel auto-repeat.
module button_conditioner #(
  parameter int CHANNELS        = 6,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  en,
  input  logic [CHANNELS-1:0]   btn_pin,
  input  logic [CHANNELS-1:0]   repeat_en,
  output logic [CHANNELS-1:0]   btn_level,
  output logic [CHANNELS-1:0]   btn_press,
  output logic [CHANNELS-1:0]   btn_release,
  output logic [CHANNELS-1:0]   btn_repeat,
  output logic [2*CHANNELS-1:0] repeat_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  localparam int DB_CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_CW  = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_CW-1:0] RD_LAST = RP_CW'(REPEAT_DELAY - 1);
  localparam logic [RP_CW-1:0] RR_LAST = RP_CW'(REPEAT_RATE - 1);

  // Inversion happens before the synchroniser so reset (0) means "not pressed".
  logic [CHANNELS-1:0] pin_cond;
  assign pin_cond = (ACTIVE_LOW != 0) ? ~btn_pin : btn_pin;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic             press_p;
    logic             release_p;
    logic             repeat_p;
    logic [DB_CW-1:0] db_cnt;
    logic [RP_CW-1:0] rp_cnt;
    rep_state_t       state;
    logic             db_fire;
    logic             rise;
    logic             fall;

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
      end else begin
        sync_a <= pin_cond[i];
        sync_b <= sync_a;
      end
    end

    assign db_fire = en && (sync_b != level) && (db_cnt == DB_LAST);
    assign rise    = db_fire && sync_b;
    assign fall    = db_fire && !sync_b;

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        level     <= 1'b0;
        press_p   <= 1'b0;
        release_p <= 1'b0;
        repeat_p  <= 1'b0;
        db_cnt    <= '0;
        rp_cnt    <= '0;
        state     <= ST_IDLE;
      end else begin
        press_p   <= 1'b0;
        release_p <= 1'b0;
        repeat_p  <= 1'b0;
        if (en) begin
          if (sync_b == level) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            level     <= sync_b;
            db_cnt    <= '0;
            press_p   <= sync_b;
            release_p <= !sync_b;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end

          // A release (or repeat disable) always wins over a terminal count.
          case (state)
            ST_IDLE: begin
              if (rise && repeat_en[i]) begin
                state  <= ST_DELAY;
                rp_cnt <= '0;
              end
            end
            ST_DELAY: begin
              if (fall || !repeat_en[i]) begin
                state  <= ST_IDLE;
                rp_cnt <= '0;
              end else if (rp_cnt == RD_LAST) begin
                repeat_p <= 1'b1;
                rp_cnt   <= '0;
                state    <= ST_REPEAT;
              end else begin
                rp_cnt <= rp_cnt + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (fall || !repeat_en[i]) begin
                state  <= ST_IDLE;
                rp_cnt <= '0;
              end else if (rp_cnt == RR_LAST) begin
                repeat_p <= 1'b1;
                rp_cnt   <= '0;
              end else begin
                rp_cnt <= rp_cnt + 1'b1;
              end
            end
            default: begin
              state  <= ST_IDLE;
              rp_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[i]         = level;
    assign btn_press[i]         = press_p;
    assign btn_release[i]       = release_p;
    assign btn_repeat[i]        = repeat_p;
    assign repeat_state[2*i +: 2] = state;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected per-cycle output vectors are
// queued when stimulus is applied and compared one clock at a time.
module tb_button_conditioner;
  localparam int CH = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          en = 1'b1;
  logic [CH-1:0] btn_pin = '0;
  logic [CH-1:0] pin_al = '1;
  logic [CH-1:0] repeat_en = '0;

  logic [CH-1:0]   lvl, prs, rel, rpt;
  logic [CH-1:0]   lvl_a, prs_a, rel_a, rpt_a;
  logic [2*CH-1:0] st, st_a;

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .nRst(nRst), .en(en), .btn_pin(btn_pin), .repeat_en(repeat_en),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_repeat(rpt),
    .repeat_state(st)
  );

  button_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .nRst(nRst), .en(en), .btn_pin(pin_al), .repeat_en('0),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rpt_a),
    .repeat_state(st_a)
  );

  // Byte layout per instance: {repeat, release, press, level}, two bits each.
  function automatic logic [7:0] pk(input logic [1:0] l, input logic [1:0] p,
                                    input logic [1:0] r, input logic [1:0] t);
    return {t, r, p, l};
  endfunction

  function automatic logic [1:0] c0(input bit b);
    return {1'b0, b};
  endfunction

  function automatic logic [1:0] c1(input bit b);
    return {b, 1'b0};
  endfunction

  task automatic check_cycle(input string tag);
    logic [15:0] obs;
    logic [15:0] exp;
    @(posedge clk);
    #1;
    obs = {pk(lvl_a, prs_a, rel_a, rpt_a), pk(lvl, prs, rel, rpt)};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but expected queue is empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic check_state(input logic [1:0] exp, input string tag);
    checks++;
    assert (st[1:0] === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, st[1:0], exp);
    end
  endtask

  task automatic push_zero(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(16'h0000);
  endtask

  initial begin
    // Reset and idle: active-low pins held 1 must not produce anything.
    push_zero(3);
    for (int c = 1; c <= 3; c++) check_cycle("reset");
    nRst = 1'b1;
    push_zero(6);
    for (int c = 1; c <= 6; c++) check_cycle("idle");

    // Press channel 0: level and press at clock 6, channel 1 untouched.
    for (int c = 1; c <= 10; c++)
      exp_q.push_back({8'h00, pk(c0(c >= 6), c0(c == 6), 2'b00, 2'b00)});
    btn_pin = 2'b01;
    for (int c = 1; c <= 10; c++) check_cycle("press");

    // Release channel 0: release pulse at clock 6.
    for (int c = 1; c <= 8; c++)
      exp_q.push_back({8'h00, pk(c0(c < 6), 2'b00, c0(c == 6), 2'b00)});
    btn_pin = 2'b00;
    for (int c = 1; c <= 8; c++) check_cycle("release");

    // Three-clock glitch is filtered out completely.
    push_zero(12);
    btn_pin = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      check_cycle("glitch");
      if (c == 3) btn_pin = 2'b00;
    end

    // Auto-repeat: press at 6, repeats at 16,19,...,40; pin falls after 37 so
    // the level falls at 43, exactly where the next repeat would have been.
    repeat_en = 2'b01;
    for (int c = 1; c <= 50; c++)
      exp_q.push_back({8'h00, pk(c0(c >= 6 && c < 43), c0(c == 6), c0(c == 43),
                                 c0(c >= 16 && c < 43 && (c - 16) % 3 == 0))});
    btn_pin = 2'b01;
    for (int c = 1; c <= 50; c++) begin
      check_cycle("repeat");
      if (c == 7)  check_state(2'b01, "state_delay");
      if (c == 20) check_state(2'b10, "state_repeat");
      if (c == 37) btn_pin = 2'b00;
      if (c == 45) check_state(2'b00, "state_idle");
    end

    // Enabling repeat while already held does not start repeating.
    repeat_en = 2'b00;
    for (int c = 1; c <= 38; c++)
      exp_q.push_back({8'h00, pk(c0(c >= 6 && c < 36), c0(c == 6), c0(c == 36), 2'b00)});
    btn_pin = 2'b01;
    for (int c = 1; c <= 38; c++) begin
      check_cycle("late_repeat_en");
      if (c == 8)  repeat_en = 2'b01;
      if (c == 30) btn_pin = 2'b00;
    end

    // Five disabled clocks mid-debounce on channel 1 delay the level by five.
    repeat_en = 2'b00;
    for (int c = 1; c <= 14; c++)
      exp_q.push_back({8'h00, pk(c1(c >= 11), c1(c == 11), 2'b00, 2'b00)});
    btn_pin = 2'b10;
    for (int c = 1; c <= 14; c++) begin
      check_cycle("en_freeze");
      if (c == 3) en = 1'b0;
      if (c == 8) en = 1'b1;
    end
    for (int c = 1; c <= 8; c++)
      exp_q.push_back({8'h00, pk(c1(c < 6), 2'b00, c1(c == 6), 2'b00)});
    btn_pin = 2'b00;
    for (int c = 1; c <= 8; c++) check_cycle("en_release");

    // Active-low instance: pin 1->0 gives a press 6 clocks later.
    for (int c = 1; c <= 20; c++)
      exp_q.push_back({pk(c0(c >= 6 && c < 18), c0(c == 6), c0(c == 18), 2'b00), 8'h00});
    pin_al = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      check_cycle("active_low");
      if (c == 12) pin_al = 2'b11;
    end

    // Reset mid-repeat with the pin held: progress discarded, fresh press after
    // normal latency and a first repeat a full delay later.
    repeat_en = 2'b01;
    for (int c = 1; c <= 18; c++)
      exp_q.push_back({8'h00, pk(c0(c >= 6), c0(c == 6), 2'b00, c0(c == 16))});
    btn_pin = 2'b01;
    for (int c = 1; c <= 18; c++) check_cycle("pre_reset");
    nRst = 1'b0;
    push_zero(3);
    for (int c = 1; c <= 3; c++) check_cycle("mid_reset");
    nRst = 1'b1;
    for (int c = 1; c <= 20; c++)
      exp_q.push_back({8'h00, pk(c0(c >= 6), c0(c == 6), 2'b00, c0(c == 16 || c == 19))});
    for (int c = 1; c <= 20; c++) check_cycle("post_reset");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover: observed %0d queued entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter CHANNELS, default 6: number of independent button channels, 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: consecutive enabled cycles an input must differ before the debounced level changes; minimum 1.
REQ-003 Parameter REPEAT_DELAY, default 12500000: enabled cycles from a press pulse to the first repeat pulse; minimum 1.
REQ-004 Parameter REPEAT_RATE, default 2500000: enabled cycles between subsequent repeat pulses; minimum 1.
REQ-005 Parameter ACTIVE_LOW, default 0: when 1, btn_pin is inverted before synchronisation.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 nRst  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  enable; 0 freezes debounce and repeat counters.
REQ-009 btn_pin  input  CHANNELS  raw asynchronous button pins.
REQ-010 repeat_en  input  CHANNELS  per-channel auto-repeat enable.
REQ-011 btn_level  output  CHANNELS  debounced pressed level, 1 = pressed.
REQ-012 btn_press  output  CHANNELS  one-clock pulse on debounced 0->1.
REQ-013 btn_release  output  CHANNELS  one-clock pulse on debounced 1->0.
REQ-014 btn_repeat  output  CHANNELS  one-clock auto-repeat pulse.

Function
REQ-015 Each channel shall pass its pin (after optional inversion) through a two-flop synchroniser; channels share no state.
REQ-016 Synchronisers shall run every clock regardless of en.
REQ-017 Each channel shall hold a debounce counter of width clog2(DEBOUNCE_CYCLES), minimum 1 bit, that resets to 0 on any cycle where synchronised input equals btn_level.
REQ-018 On an en=1 cycle with synchronised input != btn_level: if counter == DEBOUNCE_CYCLES-1, btn_level shall take the synchronised value and counter shall clear; otherwise counter shall increment.
REQ-019 A stable pin change shall appear on btn_level exactly 2+DEBOUNCE_CYCLES clocks later when en is held 1.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles shall not change btn_level or produce any pulse.
REQ-021 btn_press/btn_release shall be registered and high only in the first clock in which btn_level shows the new value.
REQ-022 Each channel shall have a repeat FSM with states IDLE, DELAY, REPEAT and a counter wide enough for max(REPEAT_DELAY, REPEAT_RATE)-1.
REQ-023 IDLE -> DELAY, counter 0, on the edge producing btn_press when repeat_en=1.
REQ-024 In DELAY, each en=1 cycle: counter == REPEAT_DELAY-1 -> btn_repeat pulse, counter 0, go REPEAT; else increment.
REQ-025 In REPEAT, each en=1 cycle: counter == REPEAT_RATE-1 -> btn_repeat pulse, counter 0; else increment.
REQ-026 From DELAY or REPEAT, btn_level falling or repeat_en=0 shall force IDLE with counter 0 and no btn_repeat that cycle; release has priority over a coinciding repeat terminal count.
REQ-027 With repeat_en=1 and en held 1, the first btn_repeat shall occur REPEAT_DELAY clocks after btn_press, then every REPEAT_RATE clocks.
REQ-028 Raising repeat_en while a button is already held shall not start repeating until the next press.
REQ-029 With en=0, all pulse outputs shall be 0 and counters, btn_level and FSM states shall hold.
REQ-030 btn_press and btn_repeat shall never be high in the same clock on the same channel.

Reset
REQ-031 nRst low shall asynchronously clear synchroniser flops to the not-pressed level (post-inversion 0), btn_level, all pulses, all counters, and all FSMs to IDLE.
REQ-032 Release of nRst with a pin held pressed shall yield btn_press after normal debounce latency, not a spurious release.
REQ-033 Reset mid-debounce or mid-repeat shall discard progress; no pulse is emitted for the interrupted sequence.

Verification (CHANNELS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-034 btn_pin[0] 0->1 held, en=1 -> btn_level[0]=1 and btn_press[0] pulse at clock 6 after change; channel 1 outputs stay 0.
REQ-035 btn_pin[0] high for 3 clocks then low -> btn_level[0], btn_press[0], btn_release[0] remain 0 throughout.
REQ-036 repeat_en[0]=1, hold 30 clocks after press -> btn_repeat[0] at press+10, +13, +16, +19, +22, +25, +28.
REQ-037 Hold with repeat, release pin -> btn_release[0] at 6 clocks after pin fall, no btn_repeat after btn_level falls.
REQ-038 ACTIVE_LOW=1, pins idle 1 through reset release -> no pulses; pin 1->0 -> btn_press after 6 clocks.
REQ-039 en=0 for 5 clocks mid-debounce -> btn_level change delayed by exactly 5 clocks, all pulses 0 while en=0.
